fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 142 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//   Load-use stall detection and EX operand bypass selection for an in-order
//   pipeline. A tag pipeline tracks the instruction in EX (stage 1) and DEPTH
//   older stages. The unit never sees data, only register tags.
//
// Parameters
//   RW     register-address width
//   NSRC   source operands per instruction (1..3)
//   DEPTH  forwarding stages after EX (2..4); SW = clog2(DEPTH+1)
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   id_valid/wr/load   ID instruction present / writes a register / is a load
//   id_rd, id_rs       ID destination and sources (operand i at [i*RW+:RW])
//   ext_hold           freeze the whole tag pipeline (flush ignored)
//   flush              kill the ID-to-EX transfer
//   stall              load-use hazard: hold PC/ID this cycle
//   fwd_sel            per-operand EX bypass select (0 = register file,
//                      k-1 = result from stage k)
//   stall_cnt, fwd_cnt saturating event counters (FWD_STATS_EN builds only)
//
// Build option
//   FWD_STATS_EN       adds stall_cnt / fwd_cnt and their logic
// -----------------------------------------------------------------------------

// Bypass select for one EX operand. Index k of the inputs is stage k+1.
module fwd_operand_sel #(
    parameter int RW    = 5,
    parameter int DEPTH = 2,
    parameter int SW    = 2
) (
    input  logic [RW-1:0]             src,
    input  logic [DEPTH:1]            vld,
    input  logic [DEPTH:1]            wr,
    input  logic [DEPTH:1][RW-1:0]    rd,
    input  logic                      ld2,
    output logic [SW-1:0]             sel
);
    // Walk oldest to youngest so the youngest match wins. A load still in
    // stage 2 has no data yet, so it is skipped and an older match is used.
    always_comb begin
        sel = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (vld[k] && wr[k] && (rd[k] != '0) && (rd[k] == src) &&
                !((k == 1) && ld2))
                sel = SW'(k);
        end
    end
endmodule

module fwd_hazard_unit #(
    parameter int RW    = 5,
    parameter int NSRC  = 2,
    parameter int DEPTH = 2,
    localparam int SW   = $clog2(DEPTH+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic                 id_wr,
    input  logic                 id_load,
    input  logic [RW-1:0]        id_rd,
    input  logic [NSRC*RW-1:0]   id_rs,
    input  logic                 ext_hold,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC*SW-1:0]   fwd_sel
`ifdef FWD_STATS_EN
   ,output logic [15:0]          stall_cnt,
    output logic [15:0]          fwd_cnt
`endif
);
    // Tag pipeline, index 0 = EX (stage 1) ... index DEPTH = stage DEPTH+1.
    logic [DEPTH:0]           vld_pipe;
    logic [DEPTH:0]           wr_pipe;
    logic [DEPTH:0][RW-1:0]   rd_pipe;
    // Load flag only matters in EX (stall) and stage 2 (no bypass yet);
    // from stage 3 on a load's data is available like any ALU result.
    logic [1:0]               ld_pipe;
    logic [NSRC-1:0][RW-1:0]  ex_rs;

    logic [NSRC-1:0]          hz;
    logic                     ex_is_load_wr;
    logic                     load_ex;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign hz[gi] = (id_rs[gi*RW +: RW] == rd_pipe[0]);

            fwd_operand_sel #(.RW(RW), .DEPTH(DEPTH), .SW(SW)) u_sel (
                .src (ex_rs[gi]),
                .vld (vld_pipe[DEPTH:1]),
                .wr  (wr_pipe[DEPTH:1]),
                .rd  (rd_pipe[DEPTH:1]),
                .ld2 (ld_pipe[1]),
                .sel (fwd_sel[gi*SW +: SW])
            );
        end
    endgenerate

    assign ex_is_load_wr = vld_pipe[0] & wr_pipe[0] & ld_pipe[0] & (rd_pipe[0] != '0);
    // Flush kills the ID instruction, so a hazard against it is moot.
    assign stall   = id_valid & ex_is_load_wr & (|hz) & ~flush;
    assign load_ex = id_valid & ~stall & ~flush;

    // Bubbles carry all-zero tags, so they can neither match nor be bypassed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            wr_pipe  <= '0;
            ld_pipe  <= '0;
            rd_pipe  <= '0;
            ex_rs    <= '0;
        end else if (!ext_hold) begin
            vld_pipe <= {vld_pipe[DEPTH-1:0], load_ex};
            wr_pipe  <= {wr_pipe[DEPTH-1:0], load_ex & id_wr};
            ld_pipe  <= {ld_pipe[0], load_ex & id_load};
            rd_pipe  <= {rd_pipe[DEPTH-1:0], (load_ex ? id_rd : '0)};
            ex_rs    <= load_ex ? id_rs : '0;
        end
    end

`ifdef FWD_STATS_EN
    logic any_fwd;
    assign any_fwd = |fwd_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && !ext_hold && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (vld_pipe[0] && any_fwd && (fwd_cnt != 16'hFFFF))
                fwd_cnt <= fwd_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
//   Directed bench. DUT a: default parameters (RW=5, NSRC=2, DEPTH=2).
//   DUT b: DEPTH=4, NSRC=3; its counters are exercised when FWD_STATS_EN is
//   defined. Expected values are queued as each step is driven and popped as
//   the outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT a
    logic        a_id_valid, a_id_wr, a_id_load, a_ext_hold, a_flush;
    logic [4:0]  a_id_rd;
    logic [9:0]  a_id_rs;
    logic        a_stall;
    logic [3:0]  a_fwd_sel;
`ifdef FWD_STATS_EN
    logic [15:0] a_stall_cnt, a_fwd_cnt;
`endif

    // DUT b
    logic        b_id_valid, b_id_wr, b_id_load, b_ext_hold, b_flush;
    logic [4:0]  b_id_rd;
    logic [14:0] b_id_rs;
    logic        b_stall;
    logic [8:0]  b_fwd_sel;
`ifdef FWD_STATS_EN
    logic [15:0] b_stall_cnt, b_fwd_cnt;
`endif

    fwd_hazard_unit u_a (
        .clk(clk), .rst_n(rst_n),
        .id_valid(a_id_valid), .id_wr(a_id_wr), .id_load(a_id_load),
        .id_rd(a_id_rd), .id_rs(a_id_rs),
        .ext_hold(a_ext_hold), .flush(a_flush),
        .stall(a_stall), .fwd_sel(a_fwd_sel)
`ifdef FWD_STATS_EN
       ,.stall_cnt(a_stall_cnt), .fwd_cnt(a_fwd_cnt)
`endif
    );

    fwd_hazard_unit #(.RW(5), .NSRC(3), .DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .id_valid(b_id_valid), .id_wr(b_id_wr), .id_load(b_id_load),
        .id_rd(b_id_rd), .id_rs(b_id_rs),
        .ext_hold(b_ext_hold), .flush(b_flush),
        .stall(b_stall), .fwd_sel(b_fwd_sel)
`ifdef FWD_STATS_EN
       ,.stall_cnt(b_stall_cnt), .fwd_cnt(b_fwd_cnt)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;
    sb_t sbq[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic push_exp(input string tag, input logic [31:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        sb_t e;
        n_vec++;
        if (sbq.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step_a(input string tag, input logic v, wr, ld,
                          input logic [4:0] rd, rs1, rs0,
                          input logic hold, fl, es, input logic [3:0] ef);
        a_id_valid = v;  a_id_wr = wr;  a_id_load = ld;
        a_id_rd = rd;    a_id_rs = {rs1, rs0};
        a_ext_hold = hold; a_flush = fl;
        push_exp({tag, "_stall"}, 32'(es));
        push_exp({tag, "_fwd"}, 32'(ef));
        @(negedge clk);
        pop_cmp(32'(a_stall));
        pop_cmp(32'(a_fwd_sel));
        @(posedge clk); #1;
    endtask

    task automatic step_b(input string tag, input logic v, wr, ld,
                          input logic [4:0] rd, rs2, rs1, rs0,
                          input logic hold, es, input logic [8:0] ef);
        b_id_valid = v;  b_id_wr = wr;  b_id_load = ld;
        b_id_rd = rd;    b_id_rs = {rs2, rs1, rs0};
        b_ext_hold = hold; b_flush = 1'b0;
        push_exp({tag, "_stall"}, 32'(es));
        push_exp({tag, "_fwd"}, 32'(ef));
        @(negedge clk);
        pop_cmp(32'(b_stall));
        pop_cmp(32'(b_fwd_sel));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a would-be hazard on the ID inputs.
        a_id_valid = 1; a_id_wr = 1; a_id_load = 1; a_id_rd = 5'd5;
        a_id_rs = {5'd5, 5'd5}; a_ext_hold = 0; a_flush = 0;
        b_id_valid = 0; b_id_wr = 0; b_id_load = 0; b_id_rd = '0;
        b_id_rs = '0; b_ext_hold = 0; b_flush = 0;
        push_exp("reset_stall", 32'd0);
        push_exp("reset_fwd", 32'd0);
        push_exp("reset_b_fwd", 32'd0);
        @(negedge clk);
        pop_cmp(32'(a_stall));
        pop_cmp(32'(a_fwd_sel));
        pop_cmp(32'(b_fwd_sel));
`ifdef FWD_STATS_EN
        push_exp("reset_b_stall_cnt", 32'd0);
        push_exp("reset_b_fwd_cnt", 32'd0);
        pop_cmp(32'(b_stall_cnt));
        pop_cmp(32'(b_fwd_cnt));
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ALU chain: add r3; sub reads r3 -> bypass from stage 2.
        step_a("c0_add_r3",   1,1,0, 5'd3,  5'd2, 5'd1, 0,0, 0, 4'h0);
        step_a("c1_sub",      1,1,0, 5'd4,  5'd0, 5'd3, 0,0, 0, 4'h0);
        step_a("c2_alu_fwd",  0,0,0, 5'd0,  5'd0, 5'd0, 0,0, 0, 4'h1);
        // Load-use: one stall cycle, bubble, then bypass from stage 3.
        step_a("c3_lw_r5",    1,1,1, 5'd5,  5'd0, 5'd6, 0,0, 0, 4'h0);
        step_a("c4_load_use", 1,1,0, 5'd8,  5'd1, 5'd5, 0,0, 1, 4'h0);
        step_a("c5_bubble",   1,1,0, 5'd8,  5'd1, 5'd5, 0,0, 0, 4'h0);
        step_a("c6_load_fwd", 0,0,0, 5'd0,  5'd0, 5'd0, 0,0, 0, 4'h2);
        // Priority: r7 written in stages 2 and 3, operand 1 reads r7.
        step_a("c7_w7a",      1,1,0, 5'd7,  5'd0, 5'd0, 0,0, 0, 4'h0);
        step_a("c8_w7b",      1,1,0, 5'd7,  5'd0, 5'd0, 0,0, 0, 4'h0);
        step_a("c9_rd_r7",    1,1,0, 5'd9,  5'd7, 5'd2, 0,0, 0, 4'h0);
        step_a("c10_prio",    0,0,0, 5'd0,  5'd0, 5'd0, 0,0, 0, 4'h4);
        // r0: load to r0 followed by r0 readers -> no stall, no bypass.
        step_a("c11_ld_r0",   1,1,1, 5'd0,  5'd0, 5'd0, 0,0, 0, 4'h0);
        step_a("c12_rd_r0",   1,1,0, 5'd10, 5'd0, 5'd0, 0,0, 0, 4'h0);
        step_a("c13_r0_fwd",  0,0,0, 5'd0,  5'd0, 5'd0, 0,0, 0, 4'h0);
        // Hold with flush asserted: bypass state frozen for 3 cycles.
        step_a("c14_w11",     1,1,0, 5'd11, 5'd0,  5'd0,  0,0, 0, 4'h0);
        step_a("c15_rd11",    1,1,0, 5'd12, 5'd11, 5'd11, 0,0, 0, 4'h0);
        step_a("c16_hold",    1,1,1, 5'd13, 5'd0,  5'd0,  1,1, 0, 4'h5);
        step_a("c17_hold",    1,1,1, 5'd13, 5'd0,  5'd0,  1,1, 0, 4'h5);
        step_a("c18_hold",    1,1,1, 5'd13, 5'd0,  5'd0,  1,1, 0, 4'h5);
        step_a("c19_unhold",  0,0,0, 5'd0,  5'd0,  5'd0,  0,0, 0, 4'h5);
        // Flush against a load-use hazard: no stall, EX gets a bubble.
        step_a("c20_lw13",    1,1,1, 5'd13, 5'd0,  5'd0,  0,0, 0, 4'h0);
        step_a("c21_flush",   1,1,1, 5'd14, 5'd0,  5'd13, 0,1, 0, 4'h0);
        step_a("c22_ex_bub",  1,1,0, 5'd15, 5'd0,  5'd14, 0,0, 0, 4'h0);
        step_a("c23_lw16",    1,1,1, 5'd16, 5'd0,  5'd0,  0,0, 0, 4'h0);

        // Reset in the middle of a stall cycle.
        a_id_valid = 1; a_id_wr = 1; a_id_load = 0; a_id_rd = 5'd17;
        a_id_rs = {5'd0, 5'd16}; a_ext_hold = 0; a_flush = 0;
        push_exp("c24_stall", 32'd1);
        push_exp("c24_fwd", 32'd0);
        @(negedge clk);
        pop_cmp(32'(a_stall));
        pop_cmp(32'(a_fwd_sel));
        #1 rst_n = 1'b0;
        #1;
        push_exp("c24_rst_stall", 32'd0);
        push_exp("c24_rst_fwd", 32'd0);
        pop_cmp(32'(a_stall));
        pop_cmp(32'(a_fwd_sel));
        @(posedge clk); #1;
        rst_n = 1'b1;
        step_a("c25_post_rst", 1,1,0, 5'd17, 5'd0, 5'd16, 0,0, 0, 4'h0);
        step_a("c26_post_fwd", 0,0,0, 5'd0,  5'd0, 5'd0,  0,0, 0, 4'h0);
        a_id_valid = 0;

        // DUT b: operand 2 from stage 5, operand 1 from stage 3.
        step_b("b0_w20",  1,1,0, 5'd20, 5'd0,  5'd0,  5'd0, 0, 0, 9'h000);
        step_b("b1_nop",  0,0,0, 5'd0,  5'd0,  5'd0,  5'd0, 0, 0, 9'h000);
        step_b("b2_w21",  1,1,0, 5'd21, 5'd0,  5'd0,  5'd0, 0, 0, 9'h000);
        step_b("b3_nop",  0,0,0, 5'd0,  5'd0,  5'd0,  5'd0, 0, 0, 9'h000);
        step_b("b4_rd",   1,1,0, 5'd24, 5'd20, 5'd21, 5'd0, 0, 0, 9'h000);
        step_b("b5_fwd",  0,0,0, 5'd0,  5'd0,  5'd0,  5'd0, 0, 0, 9'h110);
`ifdef FWD_STATS_EN
        push_exp("b5_fwd_cnt", 32'd1);
        pop_cmp(32'(b_fwd_cnt));
`endif
        // Load-use on b with ext_hold over the first two stall cycles.
        step_b("b6_lw23",  1,1,1, 5'd23, 5'd0, 5'd0, 5'd0,  0, 0, 9'h000);
        step_b("b7_hold",  1,1,0, 5'd25, 5'd0, 5'd0, 5'd23, 1, 1, 9'h000);
        step_b("b8_hold",  1,1,0, 5'd25, 5'd0, 5'd0, 5'd23, 1, 1, 9'h000);
        step_b("b9_stall", 1,1,0, 5'd25, 5'd0, 5'd0, 5'd23, 0, 1, 9'h000);
        step_b("b10_bub",  1,1,0, 5'd25, 5'd0, 5'd0, 5'd23, 0, 0, 9'h000);
        step_b("b11_fwd",  0,0,0, 5'd0,  5'd0, 5'd0, 5'd0,  0, 0, 9'h002);
`ifdef FWD_STATS_EN
        push_exp("b11_stall_cnt", 32'd1);
        push_exp("b11_fwd_cnt", 32'd2);
        pop_cmp(32'(b_stall_cnt));
        pop_cmp(32'(b_fwd_cnt));
        // Back-to-back r22 self-dependent ops forward every cycle.
        b_id_valid = 1; b_id_wr = 1; b_id_load = 0; b_id_rd = 5'd22;
        b_id_rs = {5'd0, 5'd0, 5'd22}; b_ext_hold = 0;
        repeat (70000) @(posedge clk);
        #1;
        b_id_valid = 0;
        push_exp("sat_fwd_cnt", 32'hFFFF);
        push_exp("sat_stall_cnt", 32'd1);
        pop_cmp(32'(b_fwd_cnt));
        pop_cmp(32'(b_stall_cnt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
